timer_apb_regs: RTL and testbench
=================================

Name: timer_apb_regs

Overview:
- APB slave front-end and register file for the single 8-bit timer.
- Sits directly downstream of the APB master. Decodes TDR/TCR/TSR/TCNT accesses and holds the control and data registers.
- Drives the control fields to the counter core.
- Captures the counter's overflow and underflow events as sticky TSR flags, cleared by writing 1 to the bit.

Parameters:
- ADDR_WIDTH, 8, APB address width. Only PADDR[1:0] is decoded when the upper bits are zero.
- WAIT_STATES, 0, extra access-phase cycles with PREADY low before completion (0..7).

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  register address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- tcnt_i  in  DATA_WIDTH  live counter value.
- ovf_set_i  in  1  one-cycle overflow event from the counter.
- udf_set_i  in  1  one-cycle underflow event from the counter.
- tdr_o  out  DATA_WIDTH  reload value.
- load_o  out  1  TCR.LOAD level.
- updown_o  out  1  TCR.UPDOWN (0 up, 1 down).
- en_o  out  1  TCR.EN.
- cks_o  out  2  TCR.CKS clock select.
- ovf_o  out  1  TSR overflow flag.
- udf_o  out  1  TSR underflow flag.

Behaviour:
- Reset is asynchronous, active-low, on PRESETn.
  - All registers clear to 0, FSM goes to IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - All control outputs are 0 and both flags are 0.
- Register map, byte addresses, bit positions from shared macros:
  - TDR 0x00: read/write, 8 bits.
  - TCR 0x01: read/write. Bit 7 LOAD, bit 5 UPDOWN, bit 4 EN, bits 1:0 CKS. Other bits are reserved: ignored on write, read as 0.
  - TSR 0x02: bit 0 OVF, bit 1 UDF. Write 1 to a bit clears it; writing 0 has no effect. Other bits read as 0.
  - TCNT 0x03: read-only, returns tcnt_i sampled in the completing cycle.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> ACCESS on the next clock edge; the wait counter is loaded with WAIT_STATES.
  - ACCESS decrements the wait counter while it is nonzero. PREADY=1 in the cycle where the counter is 0.
  - With WAIT_STATES=0, PREADY is high in the first ACCESS cycle, so a transfer takes 2 cycles.
  - On completion (PSEL & PENABLE & PREADY): go to SETUP if PSEL=1 and PENABLE=0 in the next cycle (back-to-back), otherwise to IDLE.
  - PSEL dropping during ACCESS before PREADY: abort, return to IDLE, no register update.
- Write commit:
  - The register updates at the clock edge ending the completing cycle.
  - The new value is visible on the outputs the following cycle.
- Read:
  - PRDATA is valid only while PREADY=1.
  - PRDATA is 0 at all other times and on errors.
- PSLVERR = 1, only in the completing cycle, for:
  - an address with nonzero upper bits, or an address beyond TCNT;
  - a write to TCNT.
  - Erroring writes change nothing.
  - PRDATA=0 on erroring reads.
- TSR flags:
  - ovf_set_i=1 sets OVF; udf_set_i=1 sets UDF. Both may set in the same cycle.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins and the flag stays 1.
  - Clearing one bit leaves the other bit unchanged.
- LOAD is a plain level bit with no auto-clear; software clears it with a second TCR write.
- PWDATA is sampled only in the completing cycle.

Decomposition:
- Shared definitions file rtl/reg_def.sv holds:
  - DATA_WIDTH;
  - TDR_ADDR, TCR_ADDR, TSR_ADDR, TCNT_ADDR;
  - TCR_LOAD_BIT, TCR_UPDOWN_BIT, TCR_EN_BIT, TCR_CKS_MSB, TCR_CKS_LSB;
  - TMR_OVF_BIT, TMR_UDF_BIT;
  - the FSM state encoding.
- One sub-module: apb_slave_if, containing the FSM, wait counter and PREADY/PSLVERR generation. It outputs wr_en, rd_en, addr and error strobes to the register file in timer_apb_regs.

Test Plan:
- Reset mid-transfer: assert PRESETn=0 during ACCESS of a TDR write of 0x5A -> TDR stays 0x00, PREADY=0, FSM in IDLE, all outputs 0.
- Write TDR 0x5A, write TCR 0xB2, read both -> tdr_o=0x5A; load_o=1, updown_o=1, en_o=1, cks_o=2'b10; reads return 0x5A and 0xB2; PSLVERR=0; each transfer takes 2 cycles.
- Pulse ovf_set_i, then read TSR -> 0x01. Write TSR 0xFF -> read TSR returns 0x00. Pulse ovf_set_i in the same cycle as the 0xFF write commit -> OVF remains 1.
- Drive tcnt_i=0x3C, read TCNT -> PRDATA=0x3C. Write 0x11 to TCNT -> PSLVERR=1 and read-back still follows tcnt_i. Read address 0x07 -> PSLVERR=1, PRDATA=0x00.
- WAIT_STATES=3, write TDR 0x77 -> PREADY low for 3 ACCESS cycles, high on the 4th; tdr_o=0x77 one cycle after completion.
- Back-to-back: a TCR write immediately followed by a TSR read with no IDLE cycle -> both complete correctly; TCR value updated before the read.

Source files
------------

// File: rtl/reg_def.sv
// Shared register map, bit positions and FSM encoding for the 8-bit timer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_def;

  // Data path width of the timer and its registers.
  localparam int DATA_WIDTH = 8;

  // Byte addresses; only PADDR[1:0] selects a register.
  localparam logic [1:0] TDR_ADDR  = 2'd0;
  localparam logic [1:0] TCR_ADDR  = 2'd1;
  localparam logic [1:0] TSR_ADDR  = 2'd2;
  localparam logic [1:0] TCNT_ADDR = 2'd3;

  // TCR field positions.
  localparam int TCR_LOAD_BIT   = 7;
  localparam int TCR_UPDOWN_BIT = 5;
  localparam int TCR_EN_BIT     = 4;
  localparam int TCR_CKS_MSB    = 1;
  localparam int TCR_CKS_LSB    = 0;

  // TSR flag positions.
  localparam int TMR_OVF_BIT = 0;
  localparam int TMR_UDF_BIT = 1;

  // APB slave FSM encoding. SETUP is only ever a decoded phase, never stored.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage

// File: rtl/timer_apb_regs_pkg.sv
// Typed views of the timer control/status registers and byte pack/unpack helpers.
// Latency: n/a (types and pure functions).
// Backpressure: n/a.
package timer_apb_regs_pkg;
  import reg_def::*;

  // Implemented TCR fields; reserved bits are simply not stored.
  typedef struct packed {
    logic       load;
    logic       updown;
    logic       en;
    logic [1:0] cks;
  } tcr_t;

  // Sticky status flags.
  typedef struct packed {
    logic udf;
    logic ovf;
  } tsr_t;

  // Place TCR fields at their architected bit positions, reserved bits read 0.
  function automatic logic [DATA_WIDTH-1:0] tcr_to_byte(input tcr_t t);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    b[TCR_LOAD_BIT]                = t.load;
    b[TCR_UPDOWN_BIT]              = t.updown;
    b[TCR_EN_BIT]                  = t.en;
    b[TCR_CKS_MSB:TCR_CKS_LSB]     = t.cks;
    return b;
  endfunction

  // Pull the implemented TCR fields out of a written byte; reserved bits dropped.
  function automatic tcr_t byte_to_tcr(input logic [DATA_WIDTH-1:0] b);
    tcr_t t;
    t.load   = b[TCR_LOAD_BIT];
    t.updown = b[TCR_UPDOWN_BIT];
    t.en     = b[TCR_EN_BIT];
    t.cks    = b[TCR_CKS_MSB:TCR_CKS_LSB];
    return t;
  endfunction

  // Place TSR flags at their bit positions, everything else reads 0.
  function automatic logic [DATA_WIDTH-1:0] tsr_to_byte(input tsr_t s);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    b[TMR_OVF_BIT] = s.ovf;
    b[TMR_UDF_BIT] = s.udf;
    return b;
  endfunction

endpackage

// File: rtl/timer_apb_regs_if.sv
// APB bus bundle between the APB master and the timer register slave.
// Latency: n/a (wiring only).
// Backpressure: slave stalls the master with PREADY low.
interface timer_apb_regs_if
  import reg_def::*;
#(
  parameter int ADDR_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_if.sv
// APB slave protocol engine: phase tracking, wait states, PREADY/PSLVERR and access strobes.
// Latency: 2 + WAIT_STATES cycles per transfer (setup, then access until the wait count hits 0).
// Backpressure: holds PREADY low for WAIT_STATES access cycles; PSEL drop before PREADY aborts.
module apb_slave_if
  import reg_def::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic                  pready_o,
  output logic                  err_o,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic [1:0]            addr_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] cur_state;
  logic [2:0] wcnt_q;
  logic [2:0] wcnt_d;
  logic       addr_bad;
  logic       wr_ro;
  logic       bad_access;
  logic       complete;

  // Any upper address bit set means the access falls outside the four-register map.
  assign addr_bad   = |paddr_i[ADDR_WIDTH-1:2];
  // TCNT is a live counter mirror and cannot be written.
  assign wr_ro      = pwrite_i && (paddr_i[1:0] == TCNT_ADDR);
  assign bad_access = addr_bad | wr_ro;

  // The setup phase is the cycle in which an idle slave first sees PSEL without PENABLE;
  // decoding it combinationally lets back-to-back transfers follow completion directly.
  assign cur_state = ((state_q == ST_IDLE) && psel_i && !penable_i) ? ST_SETUP : state_q;

  assign complete = (cur_state == ST_ACCESS) && psel_i && penable_i && (wcnt_q == 3'd0);

  assign pready_o = complete;
  assign err_o    = complete & bad_access;
  assign wr_en_o  = complete & pwrite_i & ~bad_access;
  assign rd_en_o  = complete & ~pwrite_i & ~bad_access;
  assign addr_o   = paddr_i[1:0];

  // Next-state and wait-count logic for the IDLE/SETUP/ACCESS sequence.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (cur_state)
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wcnt_d  = 3'(WAIT_STATES);
      end
      ST_ACCESS: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else if (penable_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: rtl/timer_apb_regs.sv
// APB register file for the 8-bit timer: TDR, TCR, sticky W1C TSR and read-only TCNT mirror.
// Latency: writes visible on control outputs the cycle after the completing APB cycle; reads return in the completing cycle.
// Backpressure: PREADY held low for WAIT_STATES access cycles by the protocol engine.
module timer_apb_regs
  import reg_def::*;
  import timer_apb_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  timer_apb_regs_if.slave       apb,
  input  logic [DATA_WIDTH-1:0] tcnt_i,
  input  logic                  ovf_set_i,
  input  logic                  udf_set_i,
  output logic [DATA_WIDTH-1:0] tdr_o,
  output logic                  load_o,
  output logic                  updown_o,
  output logic                  en_o,
  output logic [1:0]            cks_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  logic                  wr_en;
  logic                  rd_en;
  logic                  err;
  logic                  pready;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] tdr_q;
  logic [DATA_WIDTH-1:0] tdr_d;
  tcr_t                  tcr_q;
  tcr_t                  tcr_d;
  tsr_t                  tsr_q;
  tsr_t                  tsr_d;
  logic [DATA_WIDTH-1:0] rdata;

  apb_slave_if #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WAIT_STATES (WAIT_STATES)
  ) u_apb (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .psel_i    (apb.PSEL),
    .penable_i (apb.PENABLE),
    .pwrite_i  (apb.PWRITE),
    .paddr_i   (apb.PADDR),
    .pready_o  (pready),
    .err_o     (err),
    .wr_en_o   (wr_en),
    .rd_en_o   (rd_en),
    .addr_o    (addr)
  );

  // Register updates from committed writes plus counter events; a same-cycle
  // event overrides a W1C clear because the set is applied last.
  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q;
    tsr_d = tsr_q;
    if (wr_en) begin
      case (addr)
        TDR_ADDR: tdr_d = apb.PWDATA;
        TCR_ADDR: tcr_d = byte_to_tcr(apb.PWDATA);
        TSR_ADDR: begin
          if (apb.PWDATA[TMR_OVF_BIT]) tsr_d.ovf = 1'b0;
          if (apb.PWDATA[TMR_UDF_BIT]) tsr_d.udf = 1'b0;
        end
        default: ;
      endcase
    end
    if (ovf_set_i) tsr_d.ovf = 1'b1;
    if (udf_set_i) tsr_d.udf = 1'b1;
  end

  // Register state; everything clears on reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tdr_q <= '0;
      tcr_q <= '0;
      tsr_q <= '0;
    end else begin
      tdr_q <= tdr_d;
      tcr_q <= tcr_d;
      tsr_q <= tsr_d;
    end
  end

  // Read mux: data only in the completing cycle of a good read, zero otherwise.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        TDR_ADDR:  rdata = tdr_q;
        TCR_ADDR:  rdata = tcr_to_byte(tcr_q);
        TSR_ADDR:  rdata = tsr_to_byte(tsr_q);
        TCNT_ADDR: rdata = tcnt_i;
        default:   rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = err;

  assign tdr_o    = tdr_q;
  assign load_o   = tcr_q.load;
  assign updown_o = tcr_q.updown;
  assign en_o     = tcr_q.en;
  assign cks_o    = tcr_q.cks;
  assign ovf_o    = tsr_q.ovf;
  assign udf_o    = tsr_q.udf;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Scoreboard bench for timer_apb_regs: two instances (0 and 3 wait states) driven by one APB master.
// Expected responses come from a byte-level register model and are queued at issue time.
// A monitor pops and compares on every PREADY; the master checks latency and control outputs.
module tb_timer_apb_regs;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    bit         err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       psel [2];
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] tcnt [2];
  logic       ovf  [2];
  logic       udf  [2];

  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];
  logic [7:0] tdr_w   [2];
  logic       load_w  [2];
  logic       upd_w   [2];
  logic       en_w    [2];
  logic [1:0] cks_w   [2];
  logic       ovf_w   [2];
  logic       udf_w   [2];

  // Reference model: plain register bytes as software sees them.
  logic [7:0] m_tdr [2];
  logic [7:0] m_tcr [2];
  logic [7:0] m_tsr [2];

  exp_t sb[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  timer_apb_regs_if #(.ADDR_WIDTH(8)) apb0 ();
  timer_apb_regs_if #(.ADDR_WIDTH(8)) apb1 ();

  assign apb0.PSEL    = psel[0];
  assign apb0.PENABLE = penable;
  assign apb0.PWRITE  = pwrite;
  assign apb0.PADDR   = paddr;
  assign apb0.PWDATA  = pwdata;
  assign apb1.PSEL    = psel[1];
  assign apb1.PENABLE = penable;
  assign apb1.PWRITE  = pwrite;
  assign apb1.PADDR   = paddr;
  assign apb1.PWDATA  = pwdata;
  assign prdata[0]  = apb0.PRDATA;
  assign pready[0]  = apb0.PREADY;
  assign pslverr[0] = apb0.PSLVERR;
  assign prdata[1]  = apb1.PRDATA;
  assign pready[1]  = apb1.PREADY;
  assign pslverr[1] = apb1.PSLVERR;

  timer_apb_regs #(.ADDR_WIDTH(8), .WAIT_STATES(WS0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .apb(apb0),
    .tcnt_i(tcnt[0]), .ovf_set_i(ovf[0]), .udf_set_i(udf[0]),
    .tdr_o(tdr_w[0]), .load_o(load_w[0]), .updown_o(upd_w[0]), .en_o(en_w[0]),
    .cks_o(cks_w[0]), .ovf_o(ovf_w[0]), .udf_o(udf_w[0])
  );

  timer_apb_regs #(.ADDR_WIDTH(8), .WAIT_STATES(WS1)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .apb(apb1),
    .tcnt_i(tcnt[1]), .ovf_set_i(ovf[1]), .udf_set_i(udf[1]),
    .tdr_o(tdr_w[1]), .load_o(load_w[1]), .updown_o(upd_w[1]), .en_o(en_w[1]),
    .cks_o(cks_w[1]), .ovf_o(ovf_w[1]), .udf_o(udf_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input bit w, input logic [7:0] a);
    return (a > 8'd3) || (w && a == 8'd3);
  endfunction

  function automatic logic [7:0] model_rd(input int d, input logic [7:0] a);
    case (a)
      8'd0:    return m_tdr[d];
      8'd1:    return m_tcr[d];
      8'd2:    return m_tsr[d];
      8'd3:    return tcnt[d];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_tdr[d] = 8'h00;
      m_tcr[d] = 8'h00;
      m_tsr[d] = 8'h00;
    end
  endtask

  // Control/status outputs versus the model, one packed comparison per instance.
  task automatic chk_outs(input int d);
    logic [14:0] act;
    logic [14:0] exp;
    act = {tdr_w[d], load_w[d], upd_w[d], en_w[d], cks_w[d], ovf_w[d], udf_w[d]};
    exp = {m_tdr[d], m_tcr[d][7], m_tcr[d][5], m_tcr[d][4], m_tcr[d][1:0], m_tsr[d][0], m_tsr[d][1]};
    check($sformatf("outs%0d", d), 32'(act), 32'(exp));
  endtask

  // One APB transfer; entered and left at posedge+1 so calls chain back-to-back.
  // so/su pulse the counter events during the completing cycle.
  task automatic apb_xfer(input int d, input bit w, input logic [7:0] a, input logic [7:0] v,
                          input bit so, input bit su);
    exp_t e;
    int   cyc;
    bit   done;
    e.rd   = !w;
    e.err  = is_err(w, a);
    e.data = e.err ? 8'h00 : model_rd(d, a);
    sb.push_back(e);
    psel[d] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = v;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc  = 2;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1;
        ovf[d] = so;
        udf[d] = su;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done) begin
      void'(sb.pop_back());
      check("pready_timeout", 32'd0, 32'd1);
    end else begin
      check($sformatf("latency%0d", d), 32'(cyc), 32'(2 + (d == 0 ? WS0 : WS1)));
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0; ovf[d] = 1'b0; udf[d] = 1'b0;
    if (done) begin
      if (w && !e.err) begin
        case (a)
          8'd0: m_tdr[d] = v;
          8'd1: m_tcr[d] = v & 8'hB3;
          8'd2: m_tsr[d] = m_tsr[d] & ~(v & 8'h03);
          default: ;
        endcase
      end
      if (so) m_tsr[d][0] = 1'b1;
      if (su) m_tsr[d][1] = 1'b1;
      chk_outs(d);
    end
  endtask

  task automatic pulse(input int d, input bit o, input bit u);
    ovf[d] = o; udf[d] = u;
    @(posedge clk); #1;
    ovf[d] = 1'b0; udf[d] = 1'b0;
    if (o) m_tsr[d][0] = 1'b1;
    if (u) m_tsr[d][1] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Response monitor: every completion pops one expectation; outside completions the bus must be quiet.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pready[d] === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: dut%0d completed with no expected response", d);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(mon_e.err));
          if (mon_e.rd) check($sformatf("prdata%0d", d), 32'(prdata[d]), 32'(mon_e.data));
        end
      end else begin
        check($sformatf("quiet_prdata%0d", d), 32'(prdata[d]), 32'h0);
        check($sformatf("quiet_pslverr%0d", d), 32'(pslverr[d]), 32'h0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    psel[0] = 1'b0; psel[1] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    for (int d = 0; d < 2; d++) begin
      tcnt[d] = 8'h00; ovf[d] = 1'b0; udf[d] = 1'b0;
    end
    model_reset();
    idle(3);
    check("rst_pready0", 32'(pready[0]), 32'h0);
    check("rst_pready1", 32'(pready[1]), 32'h0);
    chk_outs(0);
    chk_outs(1);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a waited TDR write: nothing commits.
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h5A;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pready", 32'(pready[1]), 32'h0);
    chk_outs(1);
    chk_outs(0);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // Basic register access on the zero-wait instance.
    apb_xfer(0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0);
    apb_xfer(0, 1'b1, 8'h01, 8'hB2, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    idle(1);

    // Sticky flags and write-1-to-clear, including set winning over clear.
    pulse(0, 1'b1, 1'b0);
    apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
    apb_xfer(0, 1'b1, 8'h02, 8'hFF, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
    pulse(0, 1'b1, 1'b1);
    apb_xfer(0, 1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
    apb_xfer(0, 1'b1, 8'h02, 8'hFF, 1'b1, 1'b0);
    apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0);

    // TCNT mirror, illegal TCNT write and out-of-range address.
    tcnt[0] = 8'h3C;
    apb_xfer(0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0);
    apb_xfer(0, 1'b1, 8'h03, 8'h11, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0);
    apb_xfer(0, 1'b1, 8'h40, 8'h99, 1'b0, 1'b0);

    // Waited transfer on the three-wait instance.
    apb_xfer(1, 1'b1, 8'h00, 8'h77, 1'b0, 1'b0);
    apb_xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Back-to-back TCR write, TCR read and TSR read with no idle cycle.
    apb_xfer(0, 1'b1, 8'h01, 8'h5F, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
    idle(1);

    // Abort: PSEL dropped during the wait states leaves TDR untouched.
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    idle(1);
    chk_outs(1);
    apb_xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized traffic across both instances.
    for (int n = 0; n < 300; n++) begin
      int         d;
      int         r;
      bit         w;
      logic [7:0] a;
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      a = (r < 8) ? 8'(r % 4) : 8'($urandom_range(4, 255));
      w = 1'($urandom_range(0, 1));
      tcnt[d] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) pulse(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      apb_xfer(d, w, a, 8'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
